multicycle_control_unit: RTL and testbench
==========================================

# multicycle_control_unit

Multi-cycle RV32I control unit that replaces the single-cycle decoder with a state machine sequencing fetch, decode, execute, memory and write-back phases. It sits beside the RV32I datapath, driving the same mux/enable controls plus a PC enable. It handles a data bus with a variable-latency ready handshake and a timeout, flags illegal opcodes, and counts retired instructions.

## Interface
- `USE_BUS_READY`, default 1: 1 = memory states wait for `busReady`; 0 = memory states last exactly 1 cycle and `busReady` is ignored.
- `MEM_TIMEOUT`, default 16: maximum memory-state cycles before abort; legal range ≥1.
- `CNT_W`, default 32: width of `instret`.
- `clk` in 1: clock; all state changes on rising edge.
- `reset` in 1: synchronous, active-high.
- `instrCode` in 32: current instruction; the datapath holds it stable from DECODE until the instruction retires.
- `busReady` in 1: data bus completion, sampled in S_MEM/L_MEM.
- `PCEn` out 1: PC update strobe; 1-cycle pulse in each instruction's final cycle.
- `regFileWe` out 1: register-file write enable.
- `aluControl` out 4: ALU op, `{instr[30], funct3}` encoding; ADD = 4'b0000.
- `aluSrcMuxSel` out 1: 1 = immediate operand.
- `busWe` out 1: data bus write.
- `busRe` out 1: data bus read.
- `RFWDSrcMuxSel` out 3: write-back source: 000 ALU, 001 bus, 010 LUI imm, 011 AUIPC, 100 PC+4.
- `branch`, `jal`, `jalr` out 1 each: PC-source controls.
- `illegalInstr` out 1: 1-cycle pulse on an unknown opcode.
- `busError` out 1: 1-cycle pulse on a memory timeout.
- `instret` out CNT_W: retired instruction count; wraps modulo 2^CNT_W.

## Operation
- Opcode map: R 0110011, S 0100011, L 0000011, I 0010011, B 1100011, LU 0110111, AU 0010111, J 1101111, JL 1100111.
- States: FETCH, DECODE, EXE, S_MEM, L_MEM, L_WB.
- FETCH: all controls 0. Next state is DECODE.
- DECODE: all controls 0.
  - L goes to EXE (load address phase).
  - S goes to EXE.
  - Any other known opcode goes to EXE.
  - An unknown opcode asserts `illegalInstr` and `PCEn`, then goes to FETCH.
- EXE, by opcode:
  - R: `regFileWe`=1, aluControl=operator. Then `PCEn`, FETCH.
  - I: `regFileWe`=1, `aluSrcMuxSel`=1. aluControl=operator when funct3=101, otherwise {0,funct3}. Then `PCEn`, FETCH.
  - B: `branch`=1, aluControl=operator. Then `PCEn`, FETCH.
  - LU: `regFileWe`=1, RFWD=010. Then `PCEn`, FETCH.
  - AU: `regFileWe`=1, RFWD=011. Then `PCEn`, FETCH.
  - J: `regFileWe`=1, RFWD=100, `jal`=1. Then `PCEn`, FETCH.
  - JL: `regFileWe`=1, RFWD=100, `jal`=1, `jalr`=1. Then `PCEn`, FETCH.
  - S: `aluSrcMuxSel`=1, ADD. Next state is S_MEM.
  - L: `aluSrcMuxSel`=1, ADD. Next state is L_MEM.
- S_MEM:
  - Holds `aluSrcMuxSel`=1, ADD, `busWe`=1 every cycle in the state.
  - On completion: `PCEn`, then FETCH.
- L_MEM:
  - Holds `aluSrcMuxSel`=1, ADD, `busRe`=1, RFWD=001.
  - On completion: next state is L_WB.
- L_WB: `regFileWe`=1, RFWD=001, `PCEn`=1. Next state is FETCH.
- Completion:
  - USE_BUS_READY=1: `busReady`=1 in a MEM cycle.
  - USE_BUS_READY=0: always in the first MEM cycle.
- Timeout (USE_BUS_READY=1 only):
  - A wait counter clears on MEM entry and increments each MEM cycle without `busReady`.
  - If the MEM_TIMEOUT-th MEM cycle has `busReady`=0: pulse `busError` and `PCEn` in that cycle and go to FETCH. L_WB is skipped, so no register write occurs.
  - If `busReady`=1 in that same cycle: completion wins, with no `busError`.
- `aluControl` is 4'b0000 in every state/opcode not listed above; it never drives X.
- `instret` increments by 1 in every cycle where `PCEn`=1, including illegal-instruction and timeout exits.

## Timing
- Outputs are combinational from the registered state, `instrCode`, and (in MEM states) `busReady`. State, counter and `instret` are registered.
- Reset: state=FETCH, wait counter=0, `instret`=0. Every output is 0 during and after reset until DECODE.
- A `reset` asserted mid-instruction aborts it: the next cycle is FETCH with no `PCEn`.
- Cycles per instruction:
  - R/I/B/LU/AU/J/JL: 3.
  - Illegal opcode: 2.
  - S: 3+k.
  - L: 4+k, where k = number of MEM cycles (1 when ready is immediate; MEM_TIMEOUT on timeout).
- `busWe`/`busRe` stay high continuously from MEM entry until the completion or timeout cycle inclusive.
- `PCEn` is never high for more than 1 consecutive cycle.

## Test plan
- Reset, then `add x1,x2,x3` (0x003100B3) → states FETCH, DECODE, EXE. EXE drives regFileWe=1, aluControl=0000, PCEn=1. `instret` goes 0→1.
- `srai` (0x4030D093) → aluControl=1101 and aluSrcMuxSel=1. Then `srli` (0x0030D093) → aluControl=0101.
- `lw` with `busReady` high after 3 wait cycles (USE_BUS_READY=1) → busRe high for 4 cycles, then L_WB with regFileWe=1 and RFWD=001. Total 8 cycles.
- `sw` with `busReady` held low, MEM_TIMEOUT=16 → busWe high for 16 cycles, then `busError` and `PCEn` pulse together. No regFileWe at any point. Next state FETCH.
- Opcode 0x7F → `illegalInstr` pulse in DECODE, `PCEn`=1, `instret`+1. Separately, `reset` asserted in L_MEM → FETCH next cycle with all outputs 0.
- USE_BUS_READY=0, `sw` with `busReady` tied to 0 → S_MEM lasts 1 cycle, no busError, 4-cycle instruction. With CNT_W=4, 16 retirements → `instret` wraps to 0.

Source files
------------

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control unit: sequences FETCH/DECODE/EXE/MEM/WB phases for the
// datapath, with a ready/timeout data-bus handshake, illegal-opcode trap and retire counter.
module multicycle_control_unit #(
   parameter bit          USE_BUS_READY = 1'b1,
   parameter int unsigned MEM_TIMEOUT   = 16,
   parameter int unsigned CNT_W         = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [31:0]      instrCode,
   input  logic             busReady,
   output logic             PCEn,
   output logic             regFileWe,
   output logic [3:0]       aluControl,
   output logic             aluSrcMuxSel,
   output logic             busWe,
   output logic             busRe,
   output logic [2:0]       RFWDSrcMuxSel,
   output logic             branch,
   output logic             jal,
   output logic             jalr,
   output logic             illegalInstr,
   output logic             busError,
   output logic [CNT_W-1:0] instret
);

   localparam int unsigned WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

   localparam logic [2:0] ST_FETCH  = 3'd0;
   localparam logic [2:0] ST_DECODE = 3'd1;
   localparam logic [2:0] ST_EXE    = 3'd2;
   localparam logic [2:0] ST_S_MEM  = 3'd3;
   localparam logic [2:0] ST_L_MEM  = 3'd4;
   localparam logic [2:0] ST_L_WB   = 3'd5;

   localparam logic [6:0] OP_R  = 7'b0110011;
   localparam logic [6:0] OP_S  = 7'b0100011;
   localparam logic [6:0] OP_L  = 7'b0000011;
   localparam logic [6:0] OP_I  = 7'b0010011;
   localparam logic [6:0] OP_B  = 7'b1100011;
   localparam logic [6:0] OP_LU = 7'b0110111;
   localparam logic [6:0] OP_AU = 7'b0010111;
   localparam logic [6:0] OP_J  = 7'b1101111;
   localparam logic [6:0] OP_JL = 7'b1100111;

   localparam logic [2:0] RFWD_ALU   = 3'b000;
   localparam logic [2:0] RFWD_BUS   = 3'b001;
   localparam logic [2:0] RFWD_LUI   = 3'b010;
   localparam logic [2:0] RFWD_AUIPC = 3'b011;
   localparam logic [2:0] RFWD_PC4   = 3'b100;

   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

   logic [2:0]        r_state;
   logic [2:0]        w_next;
   logic [WAIT_W-1:0] r_wait;
   logic [6:0]        w_opcode;
   logic [2:0]        w_funct3;
   logic [3:0]        w_alu_op;
   logic              w_mem_done;
   logic              w_mem_timeout;
   logic              w_known_op;
   logic              w_unused;

   assign w_opcode = instrCode[6:0];
   assign w_funct3 = instrCode[14:12];
   assign w_alu_op = {instrCode[30], instrCode[14:12]};
   assign w_unused = ^{instrCode[31], instrCode[29:15], instrCode[11:7]};

   // With the handshake disabled every memory phase completes in its first cycle.
   assign w_mem_done    = USE_BUS_READY ? busReady : 1'b1;
   assign w_mem_timeout = USE_BUS_READY && !busReady && (r_wait == WAIT_LAST);

   always_comb begin
      w_known_op = 1'b0;
      case (w_opcode)
         OP_R, OP_S, OP_L, OP_I, OP_B, OP_LU, OP_AU, OP_J, OP_JL: w_known_op = 1'b1;
         default:                                                 w_known_op = 1'b0;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_FETCH;
      end else begin
         r_state <= w_next;
      end
   end

   // Wait counter: zero outside MEM, counts cycles spent waiting for busReady
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wait <= '0;
      end else if (((r_state == ST_S_MEM) || (r_state == ST_L_MEM)) && (w_next == r_state)) begin
         r_wait <= r_wait + 1'b1;
      end else begin
         r_wait <= '0;
      end
   end

   // Retired-instruction counter
   always_ff @(posedge clk) begin
      if (reset) begin
         instret <= '0;
      end else if (PCEn) begin
         instret <= instret + CNT_W'(1);
      end
   end

   // Next state and control decode; everything held low while reset is asserted
   always_comb begin
      w_next        = r_state;
      PCEn          = 1'b0;
      regFileWe     = 1'b0;
      aluControl    = 4'b0000;
      aluSrcMuxSel  = 1'b0;
      busWe         = 1'b0;
      busRe         = 1'b0;
      RFWDSrcMuxSel = RFWD_ALU;
      branch        = 1'b0;
      jal           = 1'b0;
      jalr          = 1'b0;
      illegalInstr  = 1'b0;
      busError      = 1'b0;
      if (!reset) begin
         case (r_state)
            ST_FETCH: begin
               w_next = ST_DECODE;
            end
            ST_DECODE: begin
               if (w_known_op) begin
                  w_next = ST_EXE;
               end else begin
                  illegalInstr = 1'b1;
                  PCEn         = 1'b1;
                  w_next       = ST_FETCH;
               end
            end
            ST_EXE: begin
               PCEn   = 1'b1;
               w_next = ST_FETCH;
               case (w_opcode)
                  OP_R: begin
                     regFileWe  = 1'b1;
                     aluControl = w_alu_op;
                  end
                  OP_I: begin
                     regFileWe    = 1'b1;
                     aluSrcMuxSel = 1'b1;
                     // Only shifts use bit 30 as an operator bit; elsewhere it is immediate.
                     aluControl   = (w_funct3 == 3'b101) ? w_alu_op : {1'b0, w_funct3};
                  end
                  OP_B: begin
                     branch     = 1'b1;
                     aluControl = w_alu_op;
                  end
                  OP_LU: begin
                     regFileWe     = 1'b1;
                     RFWDSrcMuxSel = RFWD_LUI;
                  end
                  OP_AU: begin
                     regFileWe     = 1'b1;
                     RFWDSrcMuxSel = RFWD_AUIPC;
                  end
                  OP_J: begin
                     regFileWe     = 1'b1;
                     RFWDSrcMuxSel = RFWD_PC4;
                     jal           = 1'b1;
                  end
                  OP_JL: begin
                     regFileWe     = 1'b1;
                     RFWDSrcMuxSel = RFWD_PC4;
                     jal           = 1'b1;
                     jalr          = 1'b1;
                  end
                  OP_S: begin
                     PCEn         = 1'b0;
                     aluSrcMuxSel = 1'b1;
                     w_next       = ST_S_MEM;
                  end
                  OP_L: begin
                     PCEn         = 1'b0;
                     aluSrcMuxSel = 1'b1;
                     w_next       = ST_L_MEM;
                  end
                  default: begin
                     PCEn = 1'b1;
                  end
               endcase
            end
            ST_S_MEM: begin
               aluSrcMuxSel = 1'b1;
               busWe        = 1'b1;
               if (w_mem_done) begin
                  PCEn   = 1'b1;
                  w_next = ST_FETCH;
               end else if (w_mem_timeout) begin
                  PCEn     = 1'b1;
                  busError = 1'b1;
                  w_next   = ST_FETCH;
               end
            end
            ST_L_MEM: begin
               aluSrcMuxSel  = 1'b1;
               busRe         = 1'b1;
               RFWDSrcMuxSel = RFWD_BUS;
               if (w_mem_done) begin
                  w_next = ST_L_WB;
               end else if (w_mem_timeout) begin
                  PCEn     = 1'b1;
                  busError = 1'b1;
                  w_next   = ST_FETCH;
               end
            end
            ST_L_WB: begin
               regFileWe     = 1'b1;
               RFWDSrcMuxSel = RFWD_BUS;
               PCEn          = 1'b1;
               w_next        = ST_FETCH;
            end
            default: begin
               w_next = ST_FETCH;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: per-instruction expected output traces built from
// the phase rules, compared cycle by cycle on a ready-handshake and a fixed-latency instance.
module tb_multicycle_control_unit;

   localparam int unsigned TO1 = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst1, rdy1, rst2, rdy2;
   logic [31:0] instr1, instr2;
   logic        pcen1, we1, src1, bwe1, bre1, br1, jal1, jalr1, ill1, berr1;
   logic        pcen2, we2, src2, bwe2, bre2, br2, jal2, jalr2, ill2, berr2;
   logic [3:0]  alu1, alu2;
   logic [2:0]  rf1, rf2;
   logic [31:0] ir1;
   logic [3:0]  ir2;
   logic [16:0] o1, o2;

   assign o1 = {pcen1, we1, alu1, src1, bwe1, bre1, rf1, br1, jal1, jalr1, ill1, berr1};
   assign o2 = {pcen2, we2, alu2, src2, bwe2, bre2, rf2, br2, jal2, jalr2, ill2, berr2};

   multicycle_control_unit #(.USE_BUS_READY(1'b1), .MEM_TIMEOUT(TO1), .CNT_W(32)) u_dut1 (
      .clk(clk), .reset(rst1), .instrCode(instr1), .busReady(rdy1),
      .PCEn(pcen1), .regFileWe(we1), .aluControl(alu1), .aluSrcMuxSel(src1),
      .busWe(bwe1), .busRe(bre1), .RFWDSrcMuxSel(rf1), .branch(br1), .jal(jal1),
      .jalr(jalr1), .illegalInstr(ill1), .busError(berr1), .instret(ir1));

   multicycle_control_unit #(.USE_BUS_READY(1'b0), .MEM_TIMEOUT(4), .CNT_W(4)) u_dut2 (
      .clk(clk), .reset(rst2), .instrCode(instr2), .busReady(rdy2),
      .PCEn(pcen2), .regFileWe(we2), .aluControl(alu2), .aluSrcMuxSel(src2),
      .busWe(bwe2), .busRe(bre2), .RFWDSrcMuxSel(rf2), .branch(br2), .jal(jal2),
      .jalr(jalr2), .illegalInstr(ill2), .busError(berr2), .instret(ir2));

   int errors = 0;
   int checks = 0;
   logic [16:0] exp_q[$];
   int          mem_k;
   bit          mem_op;
   logic [31:0] cnt1;
   logic [3:0]  cnt2;

   logic [6:0] ops [9] = '{7'b0110011, 7'b0100011, 7'b0000011, 7'b0010011, 7'b1100011,
                           7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [16:0] mk(input logic pc, input logic we, input logic [3:0] alu,
                                       input logic src, input logic bwe, input logic bre,
                                       input logic [2:0] rf, input logic br, input logic j,
                                       input logic jr, input logic ill, input logic be);
      return {pc, we, alu, src, bwe, bre, rf, br, j, jr, ill, be};
   endfunction

   function automatic bit known(input logic [6:0] op);
      for (int i = 0; i < 9; i++) if (ops[i] == op) return 1'b1;
      return 1'b0;
   endfunction

   // Expected per-cycle outputs of a whole instruction, starting in FETCH.
   task automatic build(input logic [31:0] ins, input int lat, input bit use_rdy);
      logic [6:0] op;
      logic [2:0] f3;
      logic [3:0] opx;
      bit         to;
      bit         last;
      op  = ins[6:0];
      f3  = ins[14:12];
      opx = {ins[30], f3};
      exp_q.delete();
      mem_op = 1'b0;
      exp_q.push_back('0);
      if (!known(op)) begin
         exp_q.push_back(mk(1, 0, 4'd0, 0, 0, 0, 3'd0, 0, 0, 0, 1, 0));
         return;
      end
      exp_q.push_back('0);
      to    = use_rdy && (lat >= int'(TO1));
      mem_k = !use_rdy ? 1 : (to ? int'(TO1) : lat + 1);
      case (op)
         7'b0110011: exp_q.push_back(mk(1, 1, opx, 0, 0, 0, 3'd0, 0, 0, 0, 0, 0));
         7'b0010011: exp_q.push_back(mk(1, 1, (f3 == 3'b101) ? opx : {1'b0, f3},
                                        1, 0, 0, 3'd0, 0, 0, 0, 0, 0));
         7'b1100011: exp_q.push_back(mk(1, 0, opx, 0, 0, 0, 3'd0, 1, 0, 0, 0, 0));
         7'b0110111: exp_q.push_back(mk(1, 1, 4'd0, 0, 0, 0, 3'd2, 0, 0, 0, 0, 0));
         7'b0010111: exp_q.push_back(mk(1, 1, 4'd0, 0, 0, 0, 3'd3, 0, 0, 0, 0, 0));
         7'b1101111: exp_q.push_back(mk(1, 1, 4'd0, 0, 0, 0, 3'd4, 0, 1, 0, 0, 0));
         7'b1100111: exp_q.push_back(mk(1, 1, 4'd0, 0, 0, 0, 3'd4, 0, 1, 1, 0, 0));
         7'b0100011: begin
            mem_op = 1'b1;
            exp_q.push_back(mk(0, 0, 4'd0, 1, 0, 0, 3'd0, 0, 0, 0, 0, 0));
            for (int j = 0; j < mem_k; j++) begin
               last = (j == mem_k - 1);
               exp_q.push_back(mk(last, 0, 4'd0, 1, 1, 0, 3'd0, 0, 0, 0, 0, last && to));
            end
         end
         default: begin
            mem_op = 1'b1;
            exp_q.push_back(mk(0, 0, 4'd0, 1, 0, 0, 3'd0, 0, 0, 0, 0, 0));
            for (int j = 0; j < mem_k; j++) begin
               last = (j == mem_k - 1);
               exp_q.push_back(mk(last && to, 0, 4'd0, 1, 0, 1, 3'd1, 0, 0, 0, 0, last && to));
            end
            if (!to) exp_q.push_back(mk(1, 1, 4'd0, 0, 0, 0, 3'd1, 0, 0, 0, 0, 0));
         end
      endcase
   endtask

   // Run one instruction from FETCH; busReady rises after `lat` MEM wait cycles.
   task automatic run(input bit sel, input string tag, input logic [31:0] ins, input int lat);
      int n;
      build(ins, lat, !sel);
      n = exp_q.size();
      if (sel) instr2 = ins; else instr1 = ins;
      for (int c = 0; c < n; c++) begin
         logic r;
         if (mem_op && c >= 3 && c < 3 + mem_k) r = ((c - 3) >= lat);
         else                                    r = 1'($urandom);
         if (sel) rdy2 = r; else rdy1 = r;
         @(negedge clk);
         chk($sformatf("%s/cyc%0d", tag, c), sel ? 32'(o2) : 32'(o1), 32'(exp_q[c]));
         @(posedge clk);
         #1;
      end
      for (int c = 0; c < n; c++) begin
         if (exp_q[c][16]) begin
            if (sel) cnt2 = cnt2 + 4'd1; else cnt1 = cnt1 + 32'd1;
         end
      end
      chk({tag, "/instret"}, sel ? 32'(ir2) : ir1, sel ? 32'(cnt2) : cnt1);
   endtask

   function automatic logic [31:0] rand_instr();
      logic [31:0] r;
      int          idx;
      r   = $urandom;
      idx = $urandom_range(0, 9);
      if (idx < 9) begin
         r[6:0] = ops[idx];
      end else begin
         while (known(r[6:0])) r[6:0] = 7'($urandom);
      end
      return r;
   endfunction

   initial begin
      rst1 = 1'b1; rst2 = 1'b1; rdy1 = 1'b1; rdy2 = 1'b1;
      instr1 = 32'h0000_0003; instr2 = 32'h0000_0023;
      cnt1 = '0; cnt2 = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_outs", 32'(o1), 32'd0);
      chk("reset_instret", ir1, 32'd0);
      @(posedge clk);
      #1;
      rst1 = 1'b0;

      run(0, "add", 32'h003100B3, 0);
      run(0, "srai", 32'h4030D093, 0);
      run(0, "srli", 32'h0030D093, 0);
      run(0, "lw_lat3", 32'h0000A083, 3);
      run(0, "sw_timeout", 32'h0020A023, 100);
      run(0, "illegal_7f", 32'h0000007F, 0);
      run(0, "lw_lat15", 32'h0000A083, 15);
      run(0, "lw_timeout", 32'h0000A083, 16);
      run(0, "sw_lat15", 32'h0020A023, 15);
      run(0, "blt", 32'h4020C463, 0);
      run(0, "jalr", 32'h000080E7, 0);

      for (int i = 0; i < 40; i++) begin
         int lat;
         lat = ($urandom_range(0, 5) == 0) ? 16 + $urandom_range(0, 3) : $urandom_range(0, 4);
         run(0, $sformatf("rnd%0d", i), rand_instr(), lat);
      end

      // Reset in the middle of a load wait aborts the instruction.
      instr1 = 32'h0000A083;
      rdy1   = 1'b0;
      repeat (4) begin
         @(posedge clk);
         #1;
      end
      @(negedge clk);
      chk("lmem_before_reset", 32'(o1), 32'(mk(0, 0, 4'd0, 1, 0, 1, 3'd1, 0, 0, 0, 0, 0)));
      rst1 = 1'b1;
      @(negedge clk);
      chk("lmem_during_reset", 32'(o1), 32'd0);
      @(posedge clk);
      #1;
      rst1 = 1'b0;
      cnt1 = '0;
      chk("instret_after_reset", ir1, 32'd0);
      run(0, "after_reset_add", 32'h003100B3, 0);

      // Fixed-latency instance: stores finish in one MEM cycle, 4-bit counter wraps.
      @(posedge clk);
      #1;
      rst2 = 1'b0;
      run(1, "u0_sw", 32'h0020A023, 1000);
      for (int i = 0; i < 15; i++) begin
         run(1, $sformatf("u0_rnd%0d", i), rand_instr(), 1000);
      end
      chk("u0_wrap", 32'(ir2), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
